// File: rtl/sr_latch_driver.sv
// Clocked driver for an active-low SR NAND latch: timed s_n/r_n pulses,
// idle gap, then a Q check against the expected state.
module sr_latch_driver #(
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   output logic req_ready,
   output logic s_n,
   output logic r_n,
   input  logic q_in,
   output logic q_exp,
   output logic done,
   output logic err
);

   localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_set;
   logic            w_set_nxt;
   logic            w_accept;
   logic            w_last;

   logic            r_s_n;
   logic            r_r_n;
   logic            r_q_exp;
   logic            r_done;
   logic            r_err;
   logic            w_s_n_nxt;
   logic            w_r_n_nxt;
   logic            w_q_exp_nxt;
   logic            w_done_nxt;
   logic            w_err_nxt;

   assign w_accept = (r_state == IDLE) & (set_req | clr_req);
   assign w_last   = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_set   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_set   <= w_set_nxt;
      end
   end

   // Counter is reloaded on every state entry and parks at zero.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_set_nxt   = r_set;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = PULSE;
               w_cnt_nxt   = CW'(PULSE_W - 1);
               w_set_nxt   = set_req & ~clr_req;
            end
         end
         PULSE: begin
            if (w_last) begin
               w_state_nxt = GAP;
               w_cnt_nxt   = CW'(GAP_W - 1);
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         GAP: begin
            if (w_last) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Only one line can be low: both derive from a single command bit.
   always_comb begin
      w_s_n_nxt   = ~((w_state_nxt == PULSE) & w_set_nxt);
      w_r_n_nxt   = ~((w_state_nxt == PULSE) & ~w_set_nxt);
      w_done_nxt  = (r_state == GAP) & w_last;
      w_q_exp_nxt = w_accept ? w_set_nxt : r_q_exp;
      w_err_nxt   = r_err | (w_done_nxt & (q_in != r_q_exp));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s_n   <= 1'b1;
         r_r_n   <= 1'b1;
         r_q_exp <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_s_n   <= w_s_n_nxt;
         r_r_n   <= w_r_n_nxt;
         r_q_exp <= w_q_exp_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign req_ready = (r_state == IDLE);
   assign s_n       = r_s_n;
   assign r_n       = r_r_n;
   assign q_exp     = r_q_exp;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: NAND-latch model on s_n/r_n with a stuck-at-0
// override, directed scenarios and a random run against a timing model.
module tb_sr_latch_driver;

   localparam int P = 2;
   localparam int G = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic set_req = 1'b0;
   logic clr_req = 1'b0;
   logic req_ready, s_n, r_n, q_in, q_exp, done, err;

   logic q_lat = 1'b0;
   logic stuck = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // Model state: edge count, edge of last accept, command, expectations.
   int n = 0;
   int k_acc = -1000;
   bit m_set = 1'b0;
   bit m_qexp = 1'b0;
   bit m_err = 1'b0;
   logic q_prev;

   sr_latch_driver #(.PULSE_W(P), .GAP_W(G)) dut (
      .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
      .req_ready(req_ready), .s_n(s_n), .r_n(r_n), .q_in(q_in),
      .q_exp(q_exp), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(s_n, r_n) begin
      if (s_n === 1'b0) q_lat = 1'b1;
      else if (r_n === 1'b0) q_lat = 1'b0;
   end

   assign q_in = stuck ? 1'b0 : q_lat;

   always @(negedge clk) begin
      if (s_n === 1'b0 && r_n === 1'b0) begin
         miscompares++;
         $display("FAIL forbidden_input s_n=%b r_n=%b at edge %0d (need not both 0)",
                  s_n, r_n, n);
      end
   end

   function automatic bit e_sn();
      return !(m_set && (n - k_acc) < P);
   endfunction
   function automatic bit e_rn();
      return !(!m_set && (n - k_acc) < P);
   endfunction
   function automatic bit e_done();
      return (n - k_acc) == P + G;
   endfunction
   function automatic bit e_ready();
      return (n - k_acc) >= P + G;
   endfunction

   task automatic tick(input bit s, input bit c, input bit r);
      bit was_ready;
      set_req = s;
      clr_req = c;
      rst = r;
      q_prev = q_in;
      was_ready = e_ready();
      @(posedge clk);
      n++;
      if (r) begin
         k_acc = -1000;
         m_qexp = 1'b0;
         m_err = 1'b0;
      end else if (was_ready && (s || c)) begin
         k_acc = n;
         m_set = s && !c;
         m_qexp = m_set;
      end else if ((n - k_acc) == P + G) begin
         m_err = m_err | (q_prev != m_qexp);
      end
      #1;
   endtask

   task automatic test_reset();
      tick(0, 0, 1);
      tick(0, 0, 1);
      vectors++;
      if ({s_n, r_n, q_exp, done, err, req_ready} !== 6'b110001) begin
         miscompares++;
         $display("FAIL reset {s_n,r_n,q_exp,done,err,ready}=%b need 110001",
                  {s_n, r_n, q_exp, done, err, req_ready});
      end
      tick(0, 0, 0);
      tick(0, 0, 0);
   endtask

   task automatic test_set();
      bit [3:0] sn_e = 4'b1100;
      bit [3:0] dn_e = 4'b0001;
      tick(1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (s_n !== ~sn_e[3-i] || done !== dn_e[3-i] ||
             req_ready !== dn_e[3-i] || r_n !== 1'b1) begin
            miscompares++;
            $display("FAIL set_timing cyc%0d s_n=%b r_n=%b done=%b ready=%b need %b 1 %b %b",
                     i, s_n, r_n, done, req_ready, ~sn_e[3-i], dn_e[3-i], dn_e[3-i]);
         end
         if (i < 3) tick(0, 0, 0);
      end
      vectors++;
      if (q_exp !== 1'b1 || q_in !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL set_result q_exp=%b q_in=%b err=%b need 1 1 0",
                  q_exp, q_in, err);
      end
      tick(0, 0, 0);
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_width done=%b need 0", done);
      end
   endtask

   task automatic test_both();
      int rlow = 0;
      int slow = 0;
      tick(1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         if (r_n === 1'b0) rlow++;
         if (s_n === 1'b0) slow++;
         tick(0, 0, 0);
      end
      vectors++;
      if (rlow != P || slow != 0 || q_exp !== 1'b0 || q_in !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_wins r_low=%0d s_low=%0d q_exp=%b q_in=%b need %0d 0 0 0",
                  rlow, slow, q_exp, q_in, P);
      end
   endtask

   task automatic test_back_to_back();
      bit [7:0] sn_e = 8'b11001100;
      tick(1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (s_n !== ~sn_e[7-i]) begin
            miscompares++;
            $display("FAIL back_to_back cyc%0d s_n=%b need %b", i, s_n, ~sn_e[7-i]);
         end
         tick(1, 0, 0);
      end
      tick(0, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
   endtask

   task automatic test_busy_ignore();
      int rlow = 0;
      int dones = 0;
      tick(1, 0, 0);
      for (int i = 0; i < 6; i++) begin
         if (r_n === 1'b0) rlow++;
         if (done === 1'b1) dones++;
         tick(0, (i < 3), 0);
      end
      vectors++;
      if (rlow != 0 || dones != 1 || q_exp !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_ignore r_low=%0d dones=%0d q_exp=%b need 0 1 1",
                  rlow, dones, q_exp);
      end
   endtask

   task automatic test_stuck();
      stuck = 1'b1;
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      vectors++;
      if (done !== 1'b1 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL stuck_err done=%b err=%b need 1 1", done, err);
      end
      stuck = 1'b0;
      tick(0, 1, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      vectors++;
      if (done !== 1'b1 || err !== 1'b1 || q_in !== 1'b0) begin
         miscompares++;
         $display("FAIL err_sticky done=%b err=%b q_in=%b need 1 1 0",
                  done, err, q_in);
      end
   endtask

   task automatic test_rst_mid();
      int dones = 0;
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 1);
      vectors++;
      if (s_n !== 1'b1 || r_n !== 1'b1 || req_ready !== 1'b1 ||
          q_exp !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid s_n=%b r_n=%b ready=%b q_exp=%b err=%b done=%b need 1 1 1 0 0 0",
                  s_n, r_n, req_ready, q_exp, err, done);
      end
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, 0);
         if (done === 1'b1) dones++;
      end
      vectors++;
      if (dones != 0) begin
         miscompares++;
         $display("FAIL rst_no_done dones=%0d need 0", dones);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) stuck = ~stuck;
         tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 59) == 0));
         vectors++;
         if (s_n !== e_sn() || r_n !== e_rn() || done !== e_done() ||
             req_ready !== e_ready() || q_exp !== m_qexp || err !== m_err) begin
            miscompares++;
            $display("FAIL random i=%0d got s_n,r_n,done,rdy,qexp,err=%b%b%b%b%b%b need %b%b%b%b%b%b",
                     i, s_n, r_n, done, req_ready, q_exp, err,
                     e_sn(), e_rn(), e_done(), e_ready(), m_qexp, m_err);
         end
      end
      stuck = 1'b0;
   endtask

   initial begin
      test_reset();
      test_set();
      test_both();
      test_back_to_back();
      test_busy_ignore();
      test_stuck();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
